keyvalue_arbiter: RTL and testbench
===================================

Name: keyvalue_arbiter

Overview:
Two-requester arbiter that shares one keyvalue store instance between the Wishbone-side master (port A) and the pad-side master (port B).
- Round-robin grant, held for exactly one transaction.
- Store command is registered; response data and DUP are captured and returned to the winner with a one-cycle ACK.
- A watchdog aborts store transactions that never ACK.
- Sits between the wrapper's bus/pad decode and a single keyvalue core, replacing the current two-instance arrangement.

Parameters:
- DW, 16, data and key width on all ports.
- AW, 16, address width on all ports.
- TIMEOUT, 255, store cycles without ACK before abort; legal range 1..255.

Ports:
- sys_clk in 1: single clock.
- sys_rst_1 in 1: asynchronous reset, active-low.
- a_stb_i / b_stb_i in 1: request strobe; held high until own ACK.
- a_we_i / b_we_i in 1: write enable.
- a_adr_is_key_i / b_adr_is_key_i in 1: mode bit, forwarded to the store.
- a_dat_is_key_i / b_dat_is_key_i in 1: mode bit, forwarded to the store.
- a_adr_i / b_adr_i in AW: address/key.
- a_dat_i / b_dat_i in DW: write data.
- a_ack_o / b_ack_o out 1: one-cycle completion pulse.
- a_err_o / b_err_o out 1: high together with ack when the transaction timed out.
- a_dat_o / b_dat_o out DW: read data, valid while ack is high, held until the next ack on the same port.
- a_dup_o / b_dup_o out 1: DUP flag, same timing as dat.
- kv_stb_o, kv_cyc_o out 1: store strobe/cycle, registered, always equal.
- kv_we_o, kv_adr_is_key_o, kv_dat_is_key_o out 1: store command bits.
- kv_adr_o out AW, kv_dat_o out DW: store address and write data.
- kv_ack_i in 1, kv_dat_i in DW, kv_dup_i in 1: store response.
- status_o out 32: debug status for the logic analyzer.

Behaviour:
Reset (asynchronous assert, synchronous release):
- state=IDLE, last_grant=B, so A wins the first tie.
- All outputs 0, all counters 0.
- Reset during BUSY drops kv_stb_o/kv_cyc_o immediately; no ack is issued.

FSM states: IDLE, BUSY, RESP.
- IDLE: if any stb is high, pick the winner:
  - only one requesting → that one;
  - both requesting → the port that is not last_grant.
  - Register the winner's command onto kv_*, set kv_stb_o=kv_cyc_o=1, reset wdog=0, go to BUSY.
- BUSY: kv_* outputs are frozen.
  - kv_ack_i=1 → capture kv_dat_i/kv_dup_i into the winner's dat/dup registers; drop kv_stb/cyc; last_grant=winner; go to RESP.
  - otherwise wdog+1. If wdog reaches TIMEOUT-1 with no ack: drop kv_stb/cyc; winner dat=0, dup=0; set err flag; increment timeout counter (saturating at 255); set sticky_to; go to RESP.
  - kv_ack_i in the same cycle as the timeout → ack wins, no error.
- RESP: winner ack_o=1 for exactly one cycle (err_o=1 if timed out), then IDLE.
  - If the requester still holds stb in the next IDLE cycle, that is a new transaction.
  - The loser's stb is never dropped by the arbiter; it stays pending.

Latency (no contention, store ACK in the cycle after STB):
- stb sampled at cycle 0 → kv_stb at 1 → kv_ack at 2 → requester ack at 3.
- Back-to-back issue rate: one transaction per 4 cycles minimum.

Other rules:
- kv_ack_i in IDLE or RESP is ignored.
- Requester changes to adr/dat/we while waiting are ignored after issue.
- Fairness: with both ports continuously requesting, grants strictly alternate A,B,A,B.

status_o fields:
- [1:0] state (IDLE=0, BUSY=1, RESP=2).
- [2] current/last winner (0=A, 1=B).
- [3] sticky_to, cleared only by reset.
- [11:4] timeout count, saturating at 255.
- [19:12] grant count A, wrapping mod 256.
- [27:20] grant count B, wrapping mod 256.
- [31:28] 0.

Decomposition:
- Shared package keyvalue_pkg:
  - state enum {IDLE, BUSY, RESP};
  - port-id constants PORT_A=0, PORT_B=1;
  - default DW/AW;
  - status_o field offsets.
- One sub-module: kv_rr_arbiter (2-way round-robin pick from req[1:0] and last_grant, purely combinational).
- Top holds the FSM, watchdog, command mux/registers and response registers.

Test Plan:
1. Single A read: a_stb=1, a_adr=0x0010; store acks 1 cycle after kv_stb with kv_dat=0xBEEF, kv_dup=1 → a_ack at cycle 3, a_dat=0xBEEF, a_dup=1, a_err=0; b_ack stays 0.
2. Simultaneous request after reset: a_stb=b_stb=1 held continuously → grant order A,B,A,B; kv_adr sequence matches; status_o[19:12]=status_o[27:20]=2 after four acks.
3. Timeout: TIMEOUT=8, b_stb=1, store never acks → kv_stb high exactly 8 cycles; b_ack=b_err=1, b_dat=0; status_o[3]=1 and status_o[11:4]=1.
4. Ack on the timeout boundary: TIMEOUT=8, kv_ack_i asserted in the 8th BUSY cycle → normal completion, err=0, timeout count unchanged.
5. Reset mid-BUSY: assert sys_rst_1=0 while kv_stb=1 → kv_stb/kv_cyc=0 combinationally, no ack. After release, a pending a_stb is reissued and completes normally.
6. Write pass-through: b_we=1, b_adr_is_key=1, b_dat_is_key=0, b_adr=0x007F, b_dat=0x0042 → kv_we=1, kv_adr_is_key=1, kv_dat_is_key=0, kv_adr=0x007F, kv_dat=0x0042, all stable through BUSY.

Source files
------------

// File: rtl/keyvalue_pkg.sv
// Shared types and constants for the two-port keyvalue store arbiter.
package keyvalue_pkg;

  localparam int unsigned DEF_DW = 16;
  localparam int unsigned DEF_AW = 16;
  localparam int unsigned WDOG_W = 8;
  localparam int unsigned CNT_W  = 8;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  // Mode bits that travel with every store command.
  typedef struct packed {
    logic we;
    logic adr_is_key;
    logic dat_is_key;
  } kv_flags_t;

  // status_o field offsets
  localparam int unsigned ST_STATE_LSB  = 0;
  localparam int unsigned ST_WINNER_BIT = 2;
  localparam int unsigned ST_STICKY_BIT = 3;
  localparam int unsigned ST_TO_LSB     = 4;
  localparam int unsigned ST_GA_LSB     = 12;
  localparam int unsigned ST_GB_LSB     = 20;
  localparam int unsigned ST_RSVD_LSB   = 28;

endpackage

// File: rtl/kv_rr_arbiter.sv
// Two-way round-robin pick; on a tie the port that did not win last time is chosen.
module kv_rr_arbiter
  import keyvalue_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       valid_c,
  output logic       grant_c
);

  always_comb begin
    valid_c = |req;
    grant_c = PORT_A;
    if (req == 2'b11) begin
      grant_c = ~last_grant;
    end else if (req[1]) begin
      grant_c = PORT_B;
    end
  end

endmodule

// File: rtl/keyvalue_arbiter.sv
// Shares one keyvalue store between the Wishbone-side (A) and pad-side (B) masters:
// round-robin grant per transaction, registered store command, watchdog abort.
module keyvalue_arbiter
  import keyvalue_pkg::*;
#(
  parameter int unsigned DW      = DEF_DW,
  parameter int unsigned AW      = DEF_AW,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic          sys_clk,
  input  logic          sys_rst_1,

  input  logic          a_stb_i,
  input  logic          a_we_i,
  input  logic          a_adr_is_key_i,
  input  logic          a_dat_is_key_i,
  input  logic [AW-1:0] a_adr_i,
  input  logic [DW-1:0] a_dat_i,
  output logic          a_ack_o,
  output logic          a_err_o,
  output logic [DW-1:0] a_dat_o,
  output logic          a_dup_o,

  input  logic          b_stb_i,
  input  logic          b_we_i,
  input  logic          b_adr_is_key_i,
  input  logic          b_dat_is_key_i,
  input  logic [AW-1:0] b_adr_i,
  input  logic [DW-1:0] b_dat_i,
  output logic          b_ack_o,
  output logic          b_err_o,
  output logic [DW-1:0] b_dat_o,
  output logic          b_dup_o,

  output logic          kv_stb_o,
  output logic          kv_cyc_o,
  output logic          kv_we_o,
  output logic          kv_adr_is_key_o,
  output logic          kv_dat_is_key_o,
  output logic [AW-1:0] kv_adr_o,
  output logic [DW-1:0] kv_dat_o,
  input  logic          kv_ack_i,
  input  logic [DW-1:0] kv_dat_i,
  input  logic          kv_dup_i,

  output logic [31:0]   status_o
);

  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  state_e              state;
  logic                last_grant;
  logic                winner;
  logic                sticky_to;
  logic [WDOG_W-1:0]   wdog;
  logic [CNT_W-1:0]    to_cnt;
  logic [CNT_W-1:0]    gcnt_a;
  logic [CNT_W-1:0]    gcnt_b;
  logic [1:0]          rst_sync;
  logic                rst_n;

  logic                valid_c;
  logic                grant_c;
  kv_flags_t           sel_flags_c;
  logic [AW-1:0]       sel_adr_c;
  logic [DW-1:0]       sel_dat_c;

  // Reset asserts immediately but releases on a clock edge.
  always_ff @(posedge sys_clk or negedge sys_rst_1) begin
    if (!sys_rst_1) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign rst_n = rst_sync[1];

  kv_rr_arbiter u_rr (
    .req        ({b_stb_i, a_stb_i}),
    .last_grant (last_grant),
    .valid_c    (valid_c),
    .grant_c    (grant_c)
  );

  // Command of whichever port the arbiter is currently picking.
  always_comb begin
    sel_flags_c = '{we: a_we_i, adr_is_key: a_adr_is_key_i, dat_is_key: a_dat_is_key_i};
    sel_adr_c   = a_adr_i;
    sel_dat_c   = a_dat_i;
    if (grant_c == PORT_B) begin
      sel_flags_c = '{we: b_we_i, adr_is_key: b_adr_is_key_i, dat_is_key: b_dat_is_key_i};
      sel_adr_c   = b_adr_i;
      sel_dat_c   = b_dat_i;
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      last_grant      <= PORT_B;
      winner          <= PORT_A;
      sticky_to       <= 1'b0;
      wdog            <= '0;
      to_cnt          <= '0;
      gcnt_a          <= '0;
      gcnt_b          <= '0;
      kv_stb_o        <= 1'b0;
      kv_cyc_o        <= 1'b0;
      kv_we_o         <= 1'b0;
      kv_adr_is_key_o <= 1'b0;
      kv_dat_is_key_o <= 1'b0;
      kv_adr_o        <= '0;
      kv_dat_o        <= '0;
      a_ack_o         <= 1'b0;
      a_err_o         <= 1'b0;
      a_dat_o         <= '0;
      a_dup_o         <= 1'b0;
      b_ack_o         <= 1'b0;
      b_err_o         <= 1'b0;
      b_dat_o         <= '0;
      b_dup_o         <= 1'b0;
    end else begin
      a_ack_o <= 1'b0;
      a_err_o <= 1'b0;
      b_ack_o <= 1'b0;
      b_err_o <= 1'b0;

      case (state)
        IDLE: begin
          if (valid_c) begin
            winner          <= grant_c;
            kv_we_o         <= sel_flags_c.we;
            kv_adr_is_key_o <= sel_flags_c.adr_is_key;
            kv_dat_is_key_o <= sel_flags_c.dat_is_key;
            kv_adr_o        <= sel_adr_c;
            kv_dat_o        <= sel_dat_c;
            kv_stb_o        <= 1'b1;
            kv_cyc_o        <= 1'b1;
            wdog            <= '0;
            if (grant_c == PORT_A) begin
              gcnt_a <= gcnt_a + CNT_W'(1);
            end else begin
              gcnt_b <= gcnt_b + CNT_W'(1);
            end
            state <= BUSY;
          end
        end

        BUSY: begin
          // An ack arriving on the last watchdog cycle still completes normally.
          if (kv_ack_i) begin
            kv_stb_o   <= 1'b0;
            kv_cyc_o   <= 1'b0;
            last_grant <= winner;
            if (winner == PORT_A) begin
              a_dat_o <= kv_dat_i;
              a_dup_o <= kv_dup_i;
              a_ack_o <= 1'b1;
            end else begin
              b_dat_o <= kv_dat_i;
              b_dup_o <= kv_dup_i;
              b_ack_o <= 1'b1;
            end
            state <= RESP;
          end else if (wdog == WDOG_LAST) begin
            kv_stb_o  <= 1'b0;
            kv_cyc_o  <= 1'b0;
            sticky_to <= 1'b1;
            if (to_cnt != CNT_MAX) begin
              to_cnt <= to_cnt + CNT_W'(1);
            end
            if (winner == PORT_A) begin
              a_dat_o <= '0;
              a_dup_o <= 1'b0;
              a_ack_o <= 1'b1;
              a_err_o <= 1'b1;
            end else begin
              b_dat_o <= '0;
              b_dup_o <= 1'b0;
              b_ack_o <= 1'b1;
              b_err_o <= 1'b1;
            end
            state <= RESP;
          end else begin
            wdog <= wdog + WDOG_W'(1);
          end
        end

        RESP: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign status_o = {4'b0000, gcnt_b, gcnt_a, to_cnt, sticky_to, winner, state};

endmodule

// File: tb/tb_keyvalue_arbiter.sv
// Self-checking bench for keyvalue_arbiter: vector table plus arbitration/reset sequences.
module tb_keyvalue_arbiter;
  import keyvalue_pkg::*;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 16;
  localparam int unsigned TO = 8;
  localparam logic [15:0] RESP_XOR = 16'hBEFF;

  logic          sys_clk = 1'b0;
  logic          sys_rst_1 = 1'b0;
  logic          a_stb_i = 0, a_we_i = 0, a_adr_is_key_i = 0, a_dat_is_key_i = 0;
  logic [AW-1:0] a_adr_i = '0;
  logic [DW-1:0] a_dat_i = '0;
  logic          a_ack_o, a_err_o, a_dup_o;
  logic [DW-1:0] a_dat_o;
  logic          b_stb_i = 0, b_we_i = 0, b_adr_is_key_i = 0, b_dat_is_key_i = 0;
  logic [AW-1:0] b_adr_i = '0;
  logic [DW-1:0] b_dat_i = '0;
  logic          b_ack_o, b_err_o, b_dup_o;
  logic [DW-1:0] b_dat_o;
  logic          kv_stb_o, kv_cyc_o, kv_we_o, kv_adr_is_key_o, kv_dat_is_key_o;
  logic [AW-1:0] kv_adr_o;
  logic [DW-1:0] kv_dat_o;
  logic          kv_ack_i = 1'b0;
  logic [DW-1:0] kv_dat_i = '0;
  logic          kv_dup_i = 1'b0;
  logic [31:0]   status_o;

  keyvalue_arbiter #(.DW(DW), .AW(AW), .TIMEOUT(TO)) dut (
    .sys_clk(sys_clk), .sys_rst_1(sys_rst_1),
    .a_stb_i(a_stb_i), .a_we_i(a_we_i), .a_adr_is_key_i(a_adr_is_key_i),
    .a_dat_is_key_i(a_dat_is_key_i), .a_adr_i(a_adr_i), .a_dat_i(a_dat_i),
    .a_ack_o(a_ack_o), .a_err_o(a_err_o), .a_dat_o(a_dat_o), .a_dup_o(a_dup_o),
    .b_stb_i(b_stb_i), .b_we_i(b_we_i), .b_adr_is_key_i(b_adr_is_key_i),
    .b_dat_is_key_i(b_dat_is_key_i), .b_adr_i(b_adr_i), .b_dat_i(b_dat_i),
    .b_ack_o(b_ack_o), .b_err_o(b_err_o), .b_dat_o(b_dat_o), .b_dup_o(b_dup_o),
    .kv_stb_o(kv_stb_o), .kv_cyc_o(kv_cyc_o), .kv_we_o(kv_we_o),
    .kv_adr_is_key_o(kv_adr_is_key_o), .kv_dat_is_key_o(kv_dat_is_key_o),
    .kv_adr_o(kv_adr_o), .kv_dat_o(kv_dat_o),
    .kv_ack_i(kv_ack_i), .kv_dat_i(kv_dat_i), .kv_dup_i(kv_dup_i),
    .status_o(status_o)
  );

  always #5 sys_clk = ~sys_clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        port;
    logic [15:0] dat;
    logic        dup;
    logic        err;
  } res_t;

  typedef struct packed {
    logic        we;
    logic        aik;
    logic        dik;
    logic [15:0] adr;
    logic [15:0] dat;
  } cmd_t;

  typedef struct {
    logic        port;
    logic        we;
    logic        aik;
    logic        dik;
    logic [15:0] adr;
    logic [15:0] dat;
    int          ack_at;
    logic        dup;
  } vec_t;

  res_t res_q[$];
  cmd_t cmd_q[$];

  // Store model: acks in the ack_at-th cycle of kv_stb (0 = never), data derived from the key.
  int   ack_at = 2;
  logic resp_dup = 1'b0;
  int   stb_cnt = 0;
  int   stb_len = 0;

  always @(negedge sys_clk) begin
    if (kv_stb_o) begin
      stb_cnt = stb_cnt + 1;
    end else begin
      if (stb_cnt != 0) stb_len = stb_cnt;
      stb_cnt = 0;
    end
    kv_ack_i = kv_stb_o && (ack_at != 0) && (stb_cnt == ack_at);
    kv_dat_i = kv_adr_o ^ RESP_XOR;
    kv_dup_i = resp_dup;
  end

  // Scoreboard: store commands checked on issue and while held, responses checked on ack.
  logic kv_stb_q = 1'b0;
  cmd_t cur_exp;

  always @(negedge sys_clk) begin : mon
    cmd_t got;
    res_t r;
    got = {kv_we_o, kv_adr_is_key_o, kv_dat_is_key_o, kv_adr_o, kv_dat_o};
    chk("kv_cyc_vs_stb", kv_cyc_o, kv_stb_o);
    if (kv_stb_o && !kv_stb_q) begin
      if (cmd_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL kv_issue: unexpected store command adr=0x%0h", kv_adr_o);
      end else begin
        cur_exp = cmd_q.pop_front();
        chk("kv_cmd", got, cur_exp);
      end
    end else if (kv_stb_o) begin
      chk("kv_cmd_stable", got, cur_exp);
    end
    kv_stb_q = kv_stb_o;

    if (a_ack_o || b_ack_o) begin
      chk("ack_onehot", {a_ack_o, b_ack_o}, a_ack_o ? 2'b10 : 2'b01);
      if (res_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL ack_unexpected: a_ack=%0b b_ack=%0b", a_ack_o, b_ack_o);
      end else begin
        r = res_q.pop_front();
        chk("ack_port", b_ack_o, r.port);
        chk("ack_dat", r.port ? b_dat_o : a_dat_o, r.dat);
        chk("ack_dup", r.port ? b_dup_o : a_dup_o, r.dup);
        chk("ack_err", r.port ? b_err_o : a_err_o, r.err);
      end
    end else begin
      chk("err_without_ack", {a_err_o, b_err_o}, 2'b00);
    end
  end

  task automatic drive_port(input logic port, input logic stb, input logic we, input logic aik,
                            input logic dik, input logic [15:0] adr, input logic [15:0] dat);
    if (port == PORT_A) begin
      a_stb_i = stb; a_we_i = we; a_adr_is_key_i = aik; a_dat_is_key_i = dik;
      a_adr_i = adr; a_dat_i = dat;
    end else begin
      b_stb_i = stb; b_we_i = we; b_adr_is_key_i = aik; b_dat_is_key_i = dik;
      b_adr_i = adr; b_dat_i = dat;
    end
  endtask

  task automatic push_exp(input logic port, input logic we, input logic aik, input logic dik,
                          input logic [15:0] adr, input logic [15:0] dat, input int ackat,
                          input logic dup);
    res_t r;
    cmd_t c;
    c = {we, aik, dik, adr, dat};
    cmd_q.push_back(c);
    r.port = port;
    r.err  = (ackat == 0);
    r.dat  = r.err ? 16'h0000 : (adr ^ RESP_XOR);
    r.dup  = r.err ? 1'b0 : dup;
    res_q.push_back(r);
  endtask

  task automatic do_req(input vec_t v);
    int  lat;
    int  exp_len;
    bit  got;
    ack_at   = v.ack_at;
    resp_dup = v.dup;
    exp_len  = (v.ack_at == 0) ? TO : v.ack_at;
    push_exp(v.port, v.we, v.aik, v.dik, v.adr, v.dat, v.ack_at, v.dup);
    drive_port(v.port, 1'b1, v.we, v.aik, v.dik, v.adr, v.dat);
    got = 0;
    lat = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge sys_clk);
      if ((v.port == PORT_B) ? b_ack_o : a_ack_o) begin
        got = 1;
        lat = i;
        break;
      end
      if (i == 1) drive_port(v.port, 1'b1, ~v.we, ~v.aik, ~v.dik, ~v.adr, ~v.dat);
    end
    drive_port(v.port, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    if (!got) begin
      checks++; errors++;
      $display("FAIL req_timeout: no ack for adr=0x%0h within 40 cycles", v.adr);
    end else begin
      chk("ack_latency", 64'(lat), 64'(exp_len));
    end
    @(negedge sys_clk);
    chk("kv_stb_cycles", 64'(stb_len), 64'(exp_len));
  endtask

  task automatic do_reset();
    sys_rst_1 = 1'b0;
    repeat (3) @(negedge sys_clk);
    res_q.delete();
    cmd_q.delete();
    sys_rst_1 = 1'b1;
    repeat (4) @(negedge sys_clk);
  endtask

  vec_t vecs[6];

  initial begin
    int acks;
    bit got;

    vecs[0] = '{PORT_A, 1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, 2, 1'b1};
    vecs[1] = '{PORT_B, 1'b1, 1'b1, 1'b0, 16'h007F, 16'h0042, 3, 1'b0};
    vecs[2] = '{PORT_B, 1'b0, 1'b0, 1'b1, 16'h0123, 16'h0000, 0, 1'b1};
    vecs[3] = '{PORT_A, 1'b0, 1'b1, 1'b1, 16'h0555, 16'h0000, 8, 1'b1};
    vecs[4] = '{PORT_A, 1'b1, 1'b0, 1'b1, 16'hFFFF, 16'hA5A5, 1, 1'b0};
    vecs[5] = '{PORT_B, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 5, 1'b1};

    // Reset state
    repeat (3) @(negedge sys_clk);
    chk("rst_ctrl", {a_ack_o, a_err_o, a_dup_o, b_ack_o, b_err_o, b_dup_o,
                     kv_stb_o, kv_cyc_o, kv_we_o, kv_adr_is_key_o, kv_dat_is_key_o}, 64'h0);
    chk("rst_dat", {a_dat_o, b_dat_o, kv_adr_o, kv_dat_o}, 64'h0);
    chk("rst_status", status_o, 64'h0);
    sys_rst_1 = 1'b1;
    repeat (4) @(negedge sys_clk);

    for (int k = 0; k < 6; k++) do_req(vecs[k]);

    chk("hold_a_dat", a_dat_o, 16'hFFFF ^ RESP_XOR);
    chk("hold_a_dup", a_dup_o, 1'b0);
    chk("hold_b_dat", b_dat_o, 16'h0000 ^ RESP_XOR);
    chk("hold_b_dup", b_dup_o, 1'b1);
    chk("status_after_table", status_o, {4'h0, 8'd3, 8'd3, 8'd1, 1'b1, 1'b1, 2'd0});

    // Both ports request continuously: A must win first, then strict alternation.
    do_reset();
    ack_at = 2;
    resp_dup = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) push_exp(PORT_A, 1'b0, 1'b0, 1'b0, 16'h1111, 16'h0000, 2, 1'b0);
      else            push_exp(PORT_B, 1'b0, 1'b0, 1'b0, 16'h2222, 16'h0000, 2, 1'b0);
    end
    drive_port(PORT_A, 1'b1, 1'b0, 1'b0, 1'b0, 16'h1111, 16'h0000);
    drive_port(PORT_B, 1'b1, 1'b0, 1'b0, 1'b0, 16'h2222, 16'h0000);
    acks = 0;
    for (int i = 0; i < 60 && acks < 4; i++) begin
      @(negedge sys_clk);
      if (a_ack_o || b_ack_o) acks++;
    end
    drive_port(PORT_A, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    drive_port(PORT_B, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    chk("rr_ack_count", 64'(acks), 64'd4);
    repeat (2) @(negedge sys_clk);
    chk("rr_grant_a", status_o[ST_GA_LSB +: 8], 8'd2);
    chk("rr_grant_b", status_o[ST_GB_LSB +: 8], 8'd2);
    chk("rr_queue_drained", 64'(res_q.size() + cmd_q.size()), 64'd0);

    // Reset while the store is busy: no ack, pending request reissued afterwards.
    ack_at = 0;
    push_exp(PORT_A, 1'b0, 1'b0, 1'b0, 16'h0333, 16'h0000, 0, 1'b0);
    drive_port(PORT_A, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0333, 16'h0000);
    repeat (3) @(negedge sys_clk);
    chk("busy_before_reset", {kv_stb_o, kv_cyc_o}, 2'b11);
    sys_rst_1 = 1'b0;
    #1;
    chk("reset_drops_kv", {kv_stb_o, kv_cyc_o}, 2'b00);
    res_q.delete();
    cmd_q.delete();
    ack_at = 2;
    resp_dup = 1'b1;
    push_exp(PORT_A, 1'b0, 1'b0, 1'b0, 16'h0333, 16'h0000, 2, 1'b1);
    repeat (2) @(negedge sys_clk);
    chk("no_ack_in_reset", {a_ack_o, b_ack_o}, 2'b00);
    sys_rst_1 = 1'b1;
    got = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge sys_clk);
      if (a_ack_o) begin
        got = 1;
        break;
      end
    end
    drive_port(PORT_A, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    chk("reissue_acked", got, 1'b1);
    @(negedge sys_clk);
    chk("status_after_reissue", status_o, {4'h0, 8'd0, 8'd1, 8'd0, 1'b0, 1'b0, 2'd0});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
